ifu: RTL
========

# ifu

Instruction fetch unit for the multi-cycle MIPS32 core. Holds the program counter and fetches instructions from instruction memory over a request/acknowledge handshake. Presents the fetched word to the decoder, and computes the next PC from the `nPCOp`/`zero` pair produced by `ctrl`. The block is upstream of the decoder that generates `decdOp`, and downstream of `ctrl` for `PCWr`/`nPCOp`.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value loaded on reset.
- `ACK_TIMEOUT`, default 15: maximum cycles spent waiting in FETCH before error; range 1..255.
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock, rising edge.
- `clr`  in  1  reset.
- `PCWr`  in  1  one-cycle pulse from `ctrl`; advances PC in HOLD.
- `nPCOp`  in  2  00 seq, 01 beq, 10 j, 11 jr (see Configuration).
- `zero`  in  1  ALU zero flag; qualifies beq.
- `jr_target`  in  32  register target for jr.
- `im_ack`  in  1  instruction memory data valid.
- `im_rdata`  in  32  instruction memory read data.
- `im_req`  out  1  fetch request.
- `im_addr`  out  32  fetch address (= `pc`).
- `pc`  out  32  current PC.
- `pc4`  out  32  `pc` + 4.
- `instr`  out  32  instruction register.
- `instr_vld`  out  1  `instr` holds the word at `pc`.
- `fetch_err`  out  1  sticky fetch timeout flag.

## Operation
- States: IDLE, FETCH, HOLD, ERR.
- IDLE -> FETCH unconditionally.
- FETCH:
  - `im_req`=1, `im_addr`=`pc`.
  - On `im_ack`: `instr`<=`im_rdata`, `instr_vld`<=1, go to HOLD.
  - Otherwise increment the wait counter.
  - If the counter reaches `ACK_TIMEOUT` without ack: go to ERR, `fetch_err`<=1.
- HOLD:
  - `im_req`=0.
  - On `PCWr`: `pc`<=npc, `instr_vld`<=0, go to FETCH, wait counter cleared.
- ERR: `im_req`=0. Remain in ERR until `clr`; `PCWr` and `im_ack` are ignored.
- npc selection:
  - 00: `pc4`.
  - 01: `pc4` + (sign_ext(imm16)<<2) if `zero`, else `pc4`.
  - 10: {`pc4`[31:28], imm26, 2'b00}.
  - 11: per Configuration.
  - imm16 and imm26 are taken from `instr`.
- Arithmetic: all additions are modulo 2^32; `pc` 32'hFFFF_FFFC + 4 wraps to 0. `pc`[1:0] is always 00.
- Ignored events:
  - `PCWr` outside HOLD.
  - `im_ack` outside FETCH.
  - An `im_ack` arriving in the timeout cycle: ack wins, go to HOLD.
- Reset (`clr`=1 at a rising edge, any state including mid-fetch):
  - State IDLE, `pc`=`RESET_PC`, `instr`=0.
  - `instr_vld`=0, `fetch_err`=0, counter=0.
  - The outstanding fetch is abandoned; a late `im_ack` is ignored.

## Timing
- Reset values: `im_req`=0, `im_addr`=`pc`=`RESET_PC`, `pc4`=`RESET_PC`+4, `instr`=0, `instr_vld`=0, `fetch_err`=0.
- First edge with `clr`=0 enters FETCH; `im_req` rises the following cycle.
- `im_req` and `im_addr` are decoded from registered state and `pc`; they are glitch-free per cycle.
- Zero-wait memory: ack in the same cycle as req is legal. `im_req` is high for exactly 1 cycle, and `instr_vld` rises next cycle.
- Latency: `im_ack` in cycle N -> `instr`/`instr_vld` valid in cycle N+1.
- `PCWr` in HOLD cycle M -> new `pc` and `im_req`=1 in cycle M+1.
- `nPCOp`, `zero` and `jr_target` are sampled only on the `PCWr` edge.
- Timeout: `fetch_err` rises `ACK_TIMEOUT`+1 cycles after FETCH entry when no ack arrives.

## Configuration
- Macro: `IFU_JR_EN`.
- Defined: `nPCOp`=11 loads {`jr_target`[31:2], 2'b00} into `pc`.
- Undefined: `nPCOp`=11 behaves as 00 (`pc4`). The `jr_target` port remains present but is unused.

## Test plan
- Reset and sequential fetch: release `clr`, ack each req after 2 cycles, pulse `PCWr` with `nPCOp`=00.
  - `im_addr` sequence 0x3000, 0x3004, 0x3008.
  - `instr_vld` rises one cycle after each ack.
- beq taken and not taken: `pc`=0x3010, `instr`=0x1000FFFE (imm16 = -2), `nPCOp`=01.
  - `zero`=1 -> next `pc`=0x300C.
  - `zero`=0 -> next `pc`=0x3014.
- j and wrap: `pc`=0xFFFF_FFFC.
  - `nPCOp`=00 -> `pc`=0x0000_0000.
  - Then `instr`=0x08000C00, `nPCOp`=10 -> `pc`=0x0000_3000.
- Timeout: never assert `im_ack`.
  - `fetch_err`=1 after 16 FETCH cycles (`ACK_TIMEOUT`=15).
  - `im_req`=0 thereafter.
  - `PCWr` has no effect until `clr`.
- Reset mid-fetch: assert `clr` while `im_req`=1, then assert `im_ack` one cycle later.
  - `instr` stays 0, `pc`=0x3000.
  - A new req is issued after IDLE.
- jr, run with and without `IFU_JR_EN`: `pc`=0x3000, `nPCOp`=11, `jr_target`=0x0040_0007.
  - Defined -> `pc`=0x0040_0004.
  - Undefined -> `pc`=0x3004.

Source files
------------

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches one instruction word per
// request/acknowledge handshake, holds it for the decoder and computes the
// next PC from nPCOp/zero when ctrl pulses PCWr.
// Optional feature macro: IFU_JR_EN (enables the jr target for nPCOp = 2'b11).
module ifu #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        PCWr,
    input  logic [1:0]  nPCOp,
    input  logic        zero,
    input  logic [31:0] jr_target,
    input  logic        im_ack,
    input  logic [31:0] im_rdata,
    output logic        im_req,
    output logic [31:0] im_addr,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] instr,
    output logic        instr_vld,
    output logic        fetch_err
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold, StErr} state_e;

    localparam logic [7:0]  TimeoutCnt = 8'(ACK_TIMEOUT);
    // The PC is always word aligned, even if the parameter is not.
    localparam logic [31:0] ResetPcAl  = {RESET_PC[31:2], 2'b00};

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        vld_q, vld_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [31:0] pc4_w;
    logic [31:0] br_off;
    logic [31:0] npc;

    assign pc4_w  = pc_q + 32'd4;
    assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

`ifdef IFU_JR_EN
    logic unused_jr;
    assign unused_jr = ^jr_target[1:0];
`else
    logic unused_jr;
    assign unused_jr = ^jr_target;
`endif

    // Next-PC selection from the held instruction and the ctrl opcode.
    always_comb begin
        npc = pc4_w;
        case (nPCOp)
            2'b00: npc = pc4_w;
            2'b01: npc = zero ? (pc4_w + br_off) : pc4_w;
            2'b10: npc = {pc4_w[31:28], instr_q[25:0], 2'b00};
`ifdef IFU_JR_EN
            2'b11: npc = {jr_target[31:2], 2'b00};
`else
            2'b11: npc = pc4_w;
`endif
            default: npc = pc4_w;
        endcase
    end

    // Fetch FSM next-state: handshake, timeout counting and PC advance.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        vld_d   = vld_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                state_d = StFetch;
                cnt_d   = 8'd0;
            end
            StFetch: begin
                // An ack in the timeout cycle still wins.
                if (im_ack) begin
                    instr_d = im_rdata;
                    vld_d   = 1'b1;
                    state_d = StHold;
                end else if (cnt_q == TimeoutCnt) begin
                    err_d   = 1'b1;
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StHold: begin
                if (PCWr) begin
                    pc_d    = npc;
                    vld_d   = 1'b0;
                    cnt_d   = 8'd0;
                    state_d = StFetch;
                end
            end
            StErr: begin
                state_d = StErr;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            pc_q    <= ResetPcAl;
            instr_q <= 32'd0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign im_req    = (state_q == StFetch);
    assign im_addr   = pc_q;
    assign pc        = pc_q;
    assign pc4       = pc4_w;
    assign instr     = instr_q;
    assign instr_vld = vld_q;
    assign fetch_err = err_q;

endmodule
